// File: rtl/axi_interconnect_crossbar_wr_arbiter_pkg.sv
// Shared types and sizing helpers for the per-slave write-channel arbiter
// and its rotating-priority core.
package axi_interconnect_crossbar_wr_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } wr_state_e;

    // Number of bits needed to hold any value in 0..value, never less than 1.
    function automatic int log2(input int value);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) <= value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    function automatic int idx_width(input int num);
        return log2(num - 1);
    endfunction

endpackage

// File: rtl/axi_interconnect_crossbar_arbit_polling.sv
// Combinational rotating-priority arbiter: picks the first requester at or
// above last_user, wrapping past NUM-1 back to 0.
module axi_interconnect_crossbar_arbit_polling
    import axi_interconnect_crossbar_wr_arbiter_pkg::*;
#(
    parameter int NUM   = 4,
    parameter int WIDTH = idx_width(NUM)
) (
    input  logic [NUM-1:0]   user_req,
    input  logic [WIDTH-1:0] last_user,
    output logic [WIDTH-1:0] gnt_idx,
    output logic             gnt_any
);

    logic [2*NUM-1:0] req_dbl;
    logic [NUM-1:0]   req_rot;

    // Rotating the doubled vector puts last_user at bit 0, so a plain
    // lowest-bit-first scan yields the wrapped priority order.
    assign req_dbl = {user_req, user_req};
    assign req_rot = req_dbl[NUM-1:0] >> 0 == '0 ? '0 : NUM'(req_dbl >> last_user);

    always_comb begin
        int k;
        k       = 0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int i = 0; i < NUM; i++) begin
            if (!gnt_any && req_rot[i]) begin
                gnt_any = 1'b1;
                k       = int'(last_user) + i;
                if (k >= NUM) begin
                    k = k - NUM;
                end
                gnt_idx = WIDTH'(k);
            end
        end
    end

endmodule

// File: rtl/axi_interconnect_crossbar_wr_arbiter.sv
// Per-slave write arbiter: grants one master for a whole AW/W/B transaction,
// drives the channel mux selects and advances the round-robin pointer.
module axi_interconnect_crossbar_wr_arbiter
    import axi_interconnect_crossbar_wr_arbiter_pkg::*;
#(
    parameter int NUM     = 4,
    parameter int WIDTH   = idx_width(NUM),
    parameter int TIMEOUT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NUM-1:0]   req,
    input  logic             aw_hs,
    input  logic             w_last_hs,
    input  logic             b_hs,
    output logic             gnt_vld,
    output logic [WIDTH-1:0] gnt_idx,
    output logic [NUM-1:0]   gnt_onehot,
    output logic             aw_en,
    output logic             w_en,
    output logic             b_en,
    output logic             timeout_err
);

    localparam int CNT_W = (TIMEOUT > 1) ? log2(TIMEOUT - 1) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    wr_state_e        state_q, state_d;
    logic             gnt_vld_q, gnt_vld_d;
    logic [WIDTH-1:0] gnt_idx_q, gnt_idx_d;
    logic [NUM-1:0]   gnt_onehot_q, gnt_onehot_d;
    logic [WIDTH-1:0] ptr_q, ptr_d;
    logic             aw_done_q, aw_done_d;
    logic             w_done_q, w_done_d;
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             timeout_err_q, timeout_err_d;

    logic [WIDTH-1:0] core_idx;
    logic             core_any;
    logic             release_now;

    axi_interconnect_crossbar_arbit_polling #(
        .NUM   (NUM),
        .WIDTH (WIDTH)
    ) u_core (
        .user_req  (req),
        .last_user (ptr_q),
        .gnt_idx   (core_idx),
        .gnt_any   (core_any)
    );

    always_comb begin
        state_d       = state_q;
        gnt_vld_d     = gnt_vld_q;
        gnt_idx_d     = gnt_idx_q;
        ptr_d         = ptr_q;
        aw_done_d     = aw_done_q;
        w_done_d      = w_done_q;
        tmo_cnt_d     = '0;
        timeout_err_d = 1'b0;
        release_now   = 1'b0;

        case (state_q)
            IDLE: begin
                if (core_any) begin
                    gnt_vld_d = 1'b1;
                    gnt_idx_d = core_idx;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = XFER;
                end
            end
            XFER: begin
                if (aw_hs) aw_done_d = 1'b1;
                if (w_last_hs) w_done_d = 1'b1;
                if (aw_done_d && w_done_d) state_d = RESP;
            end
            RESP: begin
                if (b_hs) begin
                    release_now = 1'b1;
                end else if (TIMEOUT > 0 && tmo_cnt_q == TMO_LAST) begin
                    release_now   = 1'b1;
                    timeout_err_d = 1'b1;
                end else if (TIMEOUT > 0) begin
                    tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Releasing hands top priority to the master just after the owner.
        if (release_now) begin
            gnt_vld_d = 1'b0;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = IDLE;
            if (gnt_idx_q == WIDTH'(NUM - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = gnt_idx_q + WIDTH'(1);
            end
        end

        gnt_onehot_d = gnt_vld_d ? (NUM'(1) << gnt_idx_d) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            gnt_vld_q     <= 1'b0;
            gnt_idx_q     <= '0;
            gnt_onehot_q  <= '0;
            ptr_q         <= '0;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
            tmo_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            gnt_vld_q     <= gnt_vld_d;
            gnt_idx_q     <= gnt_idx_d;
            gnt_onehot_q  <= gnt_onehot_d;
            ptr_q         <= ptr_d;
            aw_done_q     <= aw_done_d;
            w_done_q      <= w_done_d;
            tmo_cnt_q     <= tmo_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign gnt_vld     = gnt_vld_q;
    assign gnt_idx     = gnt_idx_q;
    assign gnt_onehot  = gnt_onehot_q;
    assign aw_en       = (state_q == XFER) && !aw_done_q;
    assign w_en        = (state_q == XFER) && !w_done_q;
    assign b_en        = (state_q == RESP);
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_axi_interconnect_crossbar_wr_arbiter.sv
// Self-checking bench: directed transaction scenarios followed by random
// traffic, all compared cycle by cycle against a transaction-level model.
module tb_axi_interconnect_crossbar_wr_arbiter;

    localparam int NUM = 4;
    localparam int TMO = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       aw_hs, w_last_hs, b_hs;
    logic       gnt_vld;
    logic [1:0] gnt_idx;
    logic [3:0] gnt_onehot;
    logic       aw_en, w_en, b_en, timeout_err;

    int n_vec = 0;
    int n_err = 0;

    // Transaction-level reference: an owner (or -1), which halves of the
    // write are finished, how long the response has been awaited.
    int m_owner, m_ptr, m_wait;
    bit m_aw, m_w, m_terr;

    always #5 clk = ~clk;

    axi_interconnect_crossbar_wr_arbiter #(
        .NUM     (NUM),
        .WIDTH   (2),
        .TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .aw_hs       (aw_hs),
        .w_last_hs   (w_last_hs),
        .b_hs        (b_hs),
        .gnt_vld     (gnt_vld),
        .gnt_idx     (gnt_idx),
        .gnt_onehot  (gnt_onehot),
        .aw_en       (aw_en),
        .w_en        (w_en),
        .b_en        (b_en),
        .timeout_err (timeout_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_release();
        m_ptr   = (m_owner + 1) % NUM;
        m_owner = -1;
        m_aw    = 0;
        m_w     = 0;
        m_wait  = 0;
    endtask

    task automatic model_step(input logic [3:0] r, input bit a, input bit wl, input bit b, input bit rs);
        int pick;
        m_terr = 0;
        if (rs) begin
            m_owner = -1; m_ptr = 0; m_aw = 0; m_w = 0; m_wait = 0;
        end else if (m_owner < 0) begin
            pick = -1;
            for (int k = 0; k < NUM; k++) begin
                if (pick < 0 && r[(m_ptr + k) % NUM]) pick = (m_ptr + k) % NUM;
            end
            if (pick >= 0) begin
                m_owner = pick; m_aw = 0; m_w = 0; m_wait = 0;
            end
        end else if (!(m_aw && m_w)) begin
            if (a) m_aw = 1;
            if (wl) m_w = 1;
        end else begin
            m_wait++;
            if (b) begin
                model_release();
            end else if (m_wait == TMO) begin
                model_release();
                m_terr = 1;
            end
        end
    endtask

    task automatic compare_all();
        bit own;
        own = (m_owner >= 0);
        check("gnt_vld", 32'(gnt_vld), 32'(own));
        if (own) check("gnt_idx", 32'(gnt_idx), 32'(m_owner));
        check("gnt_onehot", 32'(gnt_onehot), own ? (32'd1 << m_owner) : 32'd0);
        check("aw_en", 32'(aw_en), 32'(own && !m_aw));
        check("w_en", 32'(w_en), 32'(own && !m_w));
        check("b_en", 32'(b_en), 32'(own && m_aw && m_w));
        check("timeout_err", 32'(timeout_err), 32'(m_terr));
        check("ptr", 32'(dut.ptr_q), 32'(m_ptr));
    endtask

    task automatic cycle(input logic [3:0] r, input bit a, input bit wl, input bit b, input bit rs);
        req = r; aw_hs = a; w_last_hs = wl; b_hs = b; rst = rs;
        @(posedge clk);
        model_step(r, a, wl, b, rs);
        #1;
        compare_all();
    endtask

    // One complete transaction with AW and WLAST together; returns the grantee.
    task automatic do_txn(input logic [3:0] r, output int granted);
        cycle(r, 0, 0, 0, 0);
        granted = int'(gnt_idx);
        cycle(r, 1, 1, 0, 0);
        cycle(r, 0, 0, 1, 0);
    endtask

    initial begin
        int g;
        int rr_exp[5];
        rr_exp = '{0, 1, 2, 3, 0};
        m_owner = -1; m_ptr = 0; m_aw = 0; m_w = 0; m_wait = 0; m_terr = 0;

        cycle(4'b1111, 1, 1, 1, 1);
        cycle(4'b0000, 0, 0, 0, 1);
        check("rst_idx", 32'(gnt_idx), 32'd0);

        // Single master: grant at t+1, AW at t+2, WLAST at t+4, B at t+6.
        cycle(4'b0100, 0, 0, 0, 0);
        check("single_idx", 32'(gnt_idx), 32'd2);
        cycle(4'b0000, 0, 0, 0, 0);
        cycle(4'b0000, 1, 0, 0, 0);
        check("single_aw_low", 32'(aw_en), 32'd0);
        cycle(4'b0000, 0, 0, 0, 0);
        cycle(4'b0000, 0, 1, 0, 0);
        check("single_w_low", 32'(w_en), 32'd0);
        cycle(4'b0000, 0, 0, 0, 0);
        cycle(4'b0000, 0, 0, 1, 0);
        check("single_released", 32'(gnt_vld), 32'd0);
        check("single_ptr", 32'(dut.ptr_q), 32'd3);

        // Round robin from ptr 0 with all requesting.
        cycle(4'b0000, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            do_txn(4'b1111, g);
            check("rr_order", 32'(g), 32'(rr_exp[i]));
        end

        // Priority skip: move ptr to 3, then req=0011 picks 0, then 1.
        do_txn(4'b0100, g);
        check("skip_ptr3", 32'(dut.ptr_q), 32'd3);
        do_txn(4'b0011, g);
        check("skip_wrap", 32'(g), 32'd0);
        do_txn(4'b0011, g);
        check("skip_next", 32'(g), 32'd1);

        // WLAST before AW, with duplicate and out-of-phase handshakes.
        cycle(4'b1000, 0, 0, 1, 0);
        cycle(4'b0000, 0, 1, 1, 0);
        check("order_no_resp", 32'(b_en), 32'd0);
        cycle(4'b0000, 0, 1, 0, 0);
        cycle(4'b0000, 1, 0, 0, 0);
        check("order_resp", 32'(b_en), 32'd1);
        cycle(4'b0000, 1, 1, 0, 0);
        cycle(4'b0000, 0, 0, 1, 0);

        // Timeout: no B for eight response cycles.
        cycle(4'b0010, 0, 0, 0, 0);
        cycle(4'b0000, 1, 1, 0, 0);
        for (int i = 0; i < TMO; i++) cycle(4'b0000, 0, 0, 0, 0);
        check("tmo_pulse", 32'(timeout_err), 32'd1);
        check("tmo_release", 32'(gnt_vld), 32'd0);
        check("tmo_ptr", 32'(dut.ptr_q), 32'd2);
        cycle(4'b0000, 0, 0, 0, 0);
        check("tmo_one_cycle", 32'(timeout_err), 32'd0);

        // Reset mid-transfer with AW already accepted, then a fresh grant.
        cycle(4'b1000, 0, 0, 0, 0);
        cycle(4'b0000, 1, 0, 0, 0);
        cycle(4'b0000, 0, 0, 0, 1);
        check("rst_mid_vld", 32'(gnt_vld), 32'd0);
        check("rst_mid_ptr", 32'(dut.ptr_q), 32'd0);
        do_txn(4'b0010, g);
        check("rst_regrant", 32'(g), 32'd1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            cycle(4'($urandom_range(0, 15)) & (($urandom % 4 == 0) ? 4'b0000 : 4'b1111),
                  ($urandom % 3) == 0, ($urandom % 3) == 0, ($urandom % 4) == 0,
                  ($urandom % 150) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
